// File: rtl/fifo_sync_param_if.sv
// rtl/fifo_sync_param_if.sv - handshake bundle between a FIFO user and fifo_sync_param
interface fifo_sync_param_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
);
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  rd_en;
   logic                  clr_err;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   // user side: issues requests, observes status
   modport master (
      output wr_en, data_in, rd_en, clr_err,
      input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   // FIFO side: accepts requests, reports status
   modport slave (
      input  wr_en, data_in, rd_en, clr_err,
      output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with thresholds, sticky errors and FWFT option
module fifo_sync_param #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 32,
   parameter int AF_LEVEL   = 28,
   parameter int AE_LEVEL   = 4,
   parameter bit FWFT       = 1'b0
) (
   input logic              clk,
   input logic              rst,
   fifo_sync_param_if.slave bus
);
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0]         AF_C     = CW'(AF_LEVEL);
   localparam logic [CW-1:0]         AE_C     = CW'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_nxt;
   logic                  full_q;
   logic                  empty_q;
   logic                  af_q;
   logic                  ae_q;
   logic                  ovf_q;
   logic                  unf_q;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  ovf_set;
   logic                  unf_set;

   // Pointers wrap at DEPTH-1 explicitly so DEPTH need not be a power of two
   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // A read on a full FIFO frees the slot the simultaneous write lands in
   assign wr_acc  = bus.wr_en & (~full_q | bus.rd_en);
   assign rd_acc  = bus.rd_en & ~empty_q;
   assign ovf_set = bus.wr_en & full_q & ~bus.rd_en;
   assign unf_set = bus.rd_en & empty_q;

   // Next fill level; a simultaneous accepted read and write cancel out
   always_comb begin
      count_nxt = count_q;
      if (wr_acc && !rd_acc) begin
         count_nxt = count_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
         count_nxt = count_q - 1'b1;
      end
   end

   // Level and flags registered from the next-state count so they always agree
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         af_q    <= 1'b0;
         ae_q    <= 1'b1;
      end else begin
         count_q <= count_nxt;
         full_q  <= (count_nxt == DEPTH_C);
         empty_q <= (count_nxt == '0);
         af_q    <= (count_nxt >= AF_C);
         ae_q    <= (count_nxt <= AE_C);
      end
   end

   // Read and write pointers advance only on accepted transfers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (rd_acc) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
      end
   end

   // Sticky error flags; a new error in the clearing cycle keeps its flag set
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_set | (ovf_q & ~bus.clr_err);
         unf_q <= unf_set | (unf_q & ~bus.clr_err);
      end
   end

   // Storage array, deliberately not reset; words left behind are simply unreachable
   always_ff @(posedge clk) begin
      if (wr_acc && !rst) begin
         mem[wr_ptr] <= bus.data_in;
      end
   end

   generate
      if (FWFT) begin : g_fwft
         // Head word presented combinationally; forced to zero while nothing is stored
         assign bus.data_out = empty_q ? '0 : mem[rd_ptr];
      end else begin : g_std
         logic [DATA_WIDTH-1:0] dout_q;

         // Registered read; holds the last popped word on idle or rejected reads
         always_ff @(posedge clk) begin
            if (rst) begin
               dout_q <= '0;
            end else if (rd_acc) begin
               dout_q <= mem[rd_ptr];
            end
         end

         assign bus.data_out = dout_q;
      end
   endgenerate

   assign bus.count        = count_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = af_q;
   assign bus.almost_empty = ae_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed self-checking bench for fifo_sync_param in three configurations
module tb_fifo_sync_param;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       wr  [3];
   logic       rd  [3];
   logic       clr [3];
   logic [7:0] din [3];

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // 0: DEPTH 32 standard, 1: DEPTH 24 standard, 2: DEPTH 32 FWFT
   fifo_sync_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) if0 ();
   fifo_sync_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) if1 ();
   fifo_sync_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) if2 ();

   fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(32), .AF_LEVEL(28), .AE_LEVEL(4), .FWFT(1'b0))
      u0 (.clk(clk), .rst(rst), .bus(if0));
   fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(24), .AF_LEVEL(20), .AE_LEVEL(4), .FWFT(1'b0))
      u1 (.clk(clk), .rst(rst), .bus(if1));
   fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(32), .AF_LEVEL(28), .AE_LEVEL(4), .FWFT(1'b1))
      u2 (.clk(clk), .rst(rst), .bus(if2));

   assign if0.wr_en = wr[0];  assign if0.rd_en = rd[0];  assign if0.clr_err = clr[0];  assign if0.data_in = din[0];
   assign if1.wr_en = wr[1];  assign if1.rd_en = rd[1];  assign if1.clr_err = clr[1];  assign if1.data_in = din[1];
   assign if2.wr_en = wr[2];  assign if2.rd_en = rd[2];  assign if2.clr_err = clr[2];  assign if2.data_in = din[2];

   // ---------------- behavioural model: a queue of words per FIFO ----------------
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   logic [7:0] q2 [$];
   bit         m_ovf  [3];
   bit         m_unf  [3];
   logic [7:0] m_dout [3];

   function automatic int qsize(input int id);
      case (id)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic [7:0] qfront(input int id);
      case (id)
         0:       return q0[0];
         1:       return q1[0];
         default: return q2[0];
      endcase
   endfunction

   task automatic qclear(input int id);
      case (id)
         0:       q0.delete();
         1:       q1.delete();
         default: q2.delete();
      endcase
   endtask

   task automatic qpush(input int id, input logic [7:0] v);
      case (id)
         0:       q0.push_back(v);
         1:       q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   task automatic qpop(input int id, output logic [7:0] v);
      case (id)
         0:       v = q0.pop_front();
         1:       v = q1.pop_front();
         default: v = q2.pop_front();
      endcase
   endtask

   task automatic mstep(input int id, input int depth, input bit fw);
      int sz;
      bit is_full, is_empty, wacc, racc;
      logic [7:0] v;
      if (rst) begin
         qclear(id);
         m_ovf[id]  = 1'b0;
         m_unf[id]  = 1'b0;
         m_dout[id] = 8'h00;
      end else begin
         sz       = qsize(id);
         is_full  = (sz == depth);
         is_empty = (sz == 0);
         wacc     = wr[id] && (!is_full || rd[id]);
         racc     = rd[id] && !is_empty;
         if (racc) begin
            qpop(id, v);
            if (!fw) m_dout[id] = v;
         end
         if (wacc) qpush(id, din[id]);
         m_ovf[id] = (wr[id] && is_full && !rd[id]) ? 1'b1 : (clr[id] ? 1'b0 : m_ovf[id]);
         m_unf[id] = (rd[id] && is_empty)           ? 1'b1 : (clr[id] ? 1'b0 : m_unf[id]);
      end
   endtask

   always @(posedge clk) begin
      mstep(0, 32, 1'b0);
      mstep(1, 24, 1'b0);
      mstep(2, 32, 1'b1);
   end

   // ---------------- checking ----------------
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_dut(input int id, input int depth, input int af, input int ae, input bit fw,
                          input logic [5:0] cnt, input logic f, input logic e, input logic afl,
                          input logic ael, input logic ov, input logic un, input logic [7:0] dout);
      int sz;
      sz = qsize(id);
      check($sformatf("d%0d count", id), 32'(cnt), 32'(sz));
      check($sformatf("d%0d full", id), 32'(f), 32'(sz == depth));
      check($sformatf("d%0d empty", id), 32'(e), 32'(sz == 0));
      check($sformatf("d%0d almost_full", id), 32'(afl), 32'(sz >= af));
      check($sformatf("d%0d almost_empty", id), 32'(ael), 32'(sz <= ae));
      check($sformatf("d%0d overflow", id), 32'(ov), 32'(m_ovf[id]));
      check($sformatf("d%0d underflow", id), 32'(un), 32'(m_unf[id]));
      if (!fw) check($sformatf("d%0d data_out", id), 32'(dout), 32'(m_dout[id]));
      else if (sz != 0) check($sformatf("d%0d fwft data_out", id), 32'(dout), 32'(qfront(id)));
   endtask

   // Every cycle after reset, all three DUTs are compared with the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk_dut(0, 32, 28, 4, 1'b0, if0.count, if0.full, if0.empty, if0.almost_full,
                 if0.almost_empty, if0.overflow, if0.underflow, if0.data_out);
         chk_dut(1, 24, 20, 4, 1'b0, if1.count, if1.full, if1.empty, if1.almost_full,
                 if1.almost_empty, if1.overflow, if1.underflow, if1.data_out);
         chk_dut(2, 32, 28, 4, 1'b1, if2.count, if2.full, if2.empty, if2.almost_full,
                 if2.almost_empty, if2.overflow, if2.underflow, if2.data_out);
      end
   end

   // One clock of stimulus to a single DUT; returns just after the edge that consumed it
   task automatic op(input int id, input bit w, input bit r, input logic [7:0] d, input bit c, input bit rs);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         wr[k] = 1'b0; rd[k] = 1'b0; clr[k] = 1'b0; din[k] = 8'h00;
      end
      wr[id] = w; rd[id] = r; din[id] = d; clr[id] = c; rst = rs;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nxt_wr;
      int exp_rd;
      bit w, r;
      for (int k = 0; k < 3; k++) begin
         wr[k] = 1'b0; rd[k] = 1'b0; clr[k] = 1'b0; din[k] = 8'h00;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset count", 32'(if0.count), 32'd0);
      check("reset empty", 32'(if0.empty), 32'd1);
      check("reset almost_empty", 32'(if0.almost_empty), 32'd1);
      check("reset full", 32'(if0.full), 32'd0);
      check("reset data_out", 32'(if0.data_out), 32'd0);
      check("reset fwft data_out", 32'(if2.data_out), 32'd0);

      // fill DEPTH=32 with 0x01..0x20
      for (int i = 1; i <= 32; i++) begin
         op(0, 1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
         if (i == 27) check("af before 28th write", 32'(if0.almost_full), 32'd0);
         if (i == 28) check("af after 28th write", 32'(if0.almost_full), 32'd1);
      end
      check("fill full", 32'(if0.full), 32'd1);
      check("fill count", 32'(if0.count), 32'd32);
      op(0, 1'b1, 1'b0, 8'h21, 1'b0, 1'b0);
      check("33rd write count", 32'(if0.count), 32'd32);
      check("33rd write overflow", 32'(if0.overflow), 32'd1);

      // drain in order
      for (int i = 1; i <= 32; i++) begin
         op(0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
         check("drain data", 32'(if0.data_out), 32'(i));
         if (i == 27) check("ae at count 5", 32'(if0.almost_empty), 32'd0);
         if (i == 28) check("ae at count 4", 32'(if0.almost_empty), 32'd1);
      end
      check("drain empty", 32'(if0.empty), 32'd1);
      op(0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      check("extra read underflow", 32'(if0.underflow), 32'd1);
      check("extra read data held", 32'(if0.data_out), 32'h20);

      // refill 0x41..0x60, then clr_err coinciding with a new overflow
      for (int i = 1; i <= 32; i++) op(0, 1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
      op(0, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
      check("clr+ovf overflow", 32'(if0.overflow), 32'd1);
      check("clr+ovf underflow", 32'(if0.underflow), 32'd0);
      op(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("clr overflow", 32'(if0.overflow), 32'd0);

      // full with simultaneous read and write
      op(0, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
      check("full rw count", 32'(if0.count), 32'd32);
      check("full rw overflow", 32'(if0.overflow), 32'd0);
      check("full rw data", 32'(if0.data_out), 32'h41);
      for (int i = 1; i <= 32; i++) begin
         op(0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
         check("drain2 data", 32'(if0.data_out), (i < 32) ? 32'(8'h41 + i) : 32'hAA);
      end

      // reset with a pending write at count 10
      for (int i = 0; i < 10; i++) op(0, 1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 1'b0);
      check("pre-reset count", 32'(if0.count), 32'd10);
      op(0, 1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
      check("mid reset count", 32'(if0.count), 32'd0);
      check("mid reset empty", 32'(if0.empty), 32'd1);
      check("mid reset data_out", 32'(if0.data_out), 32'd0);

      // DEPTH=24: interleaved traffic between 10 and 24 words
      nxt_wr = 0;
      exp_rd = 0;
      for (int i = 0; i < 10; i++) begin
         op(1, 1'b1, 1'b0, 8'(nxt_wr), 1'b0, 1'b0);
         nxt_wr++;
      end
      for (int i = 0; i < 100; i++) begin
         if (i < 50) begin
            w = (q1.size() < 24) && (i % 4 != 3);
            r = (q1.size() > 10) && (i % 4 == 0 || i % 4 == 3);
         end else begin
            w = (q1.size() < 24) && (i % 4 == 0);
            r = (q1.size() > 10);
         end
         op(1, w, r, 8'(nxt_wr), 1'b0, 1'b0);
         if (w) nxt_wr++;
         if (r) begin
            check("d24 order", 32'(if1.data_out), 32'(8'(exp_rd)));
            exp_rd++;
         end
         check("d24 count range", 32'(if1.count >= 6'd10 && if1.count <= 6'd24), 32'd1);
      end
      check("d24 overflow", 32'(if1.overflow), 32'd0);
      check("d24 underflow", 32'(if1.underflow), 32'd0);

      // FWFT
      op(2, 1'b1, 1'b0, 8'h5C, 1'b0, 1'b0);
      check("fwft data", 32'(if2.data_out), 32'h5C);
      check("fwft empty", 32'(if2.empty), 32'd0);
      op(2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check("fwft hold", 32'(if2.data_out), 32'h5C);
      op(2, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      check("fwft pop empty", 32'(if2.empty), 32'd1);
      op(2, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
      op(2, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
      check("fwft head", 32'(if2.data_out), 32'h11);
      op(2, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      check("fwft next", 32'(if2.data_out), 32'h22);
      check("fwft count", 32'(if2.count), 32'd1);

      op(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock synchronous FIFO, the next-generation storage buffer for the FIFO datapath. It supports configurable width, depth (not restricted to a power of two) and programmable almost-full/almost-empty thresholds. It provides a fill-level count, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It sits behind the `fifo_if` bus in place of the fixed 8x32 FIFO and is driven from the same `clk`/`rst`.

## Interface
Parameters:
- `DATA_WIDTH`, 8: word width in bits.
- `ADDR_WIDTH`, 5: pointer width in bits.
- `DEPTH`, 32: number of storage words. Legal range is 2 ≤ DEPTH ≤ 2**ADDR_WIDTH.
- `AF_LEVEL`, 28: `almost_full` asserts when count ≥ AF_LEVEL. Legal range is 1..DEPTH.
- `AE_LEVEL`, 4: `almost_empty` asserts when count ≤ AE_LEVEL. Legal range is 0..DEPTH-1.
- `FWFT`, 0: read mode. 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write request.
- `data_in` in DATA_WIDTH: write data.
- `rd_en` in 1: read/pop request.
- `data_out` out DATA_WIDTH: read data.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `almost_full` out 1: programmable threshold flag.
- `almost_empty` out 1: programmable threshold flag.
- `count` out ADDR_WIDTH+1: number of stored words, 0..DEPTH.
- `overflow` out 1: sticky; a write was dropped.
- `underflow` out 1: sticky; a read was rejected.
- `clr_err` in 1: clears `overflow` and `underflow`.

## Operation
- Write acceptance: `wr_acc = wr_en & (~full | rd_en)`. When full, a simultaneous read frees a slot, so both the read and the write are accepted.
- Read acceptance: `rd_acc = rd_en & ~empty`.
- Storage is `mem[0..DEPTH-1]`. On `wr_acc`, `mem[wr_ptr] <= data_in`. `wr_ptr` and `rd_ptr` increment on acceptance and wrap from DEPTH-1 to 0; there is no power-of-two assumption.
- Count update:
  - +1 on `wr_acc` only.
  - -1 on `rd_acc` only.
  - Unchanged when both or neither occur.
- All flags (`full`, `empty`, `almost_full`, `almost_empty`) are registered and derived from the next-state count, so they are always consistent with `count` in the same cycle.
- Standard mode (FWFT=0): on `rd_acc`, `data_out <= mem[rd_ptr]`. `data_out` holds its value otherwise, including on rejected reads.
- FWFT mode (FWFT=1): `data_out` continuously presents `mem[rd_ptr]`. Its value is valid only while `empty`=0, and `rd_en` pops that word.
- Overflow: `wr_en & full & ~rd_en` drops the write and sets `overflow` next cycle.
- Underflow: `rd_en & empty` is ignored and sets `underflow` next cycle. Pointers, count and `data_out` are unchanged.
- Error clear: `clr_err` clears both sticky flags next cycle. If a new error event coincides with `clr_err`, the set wins.
- Reset outputs: `count`=0, `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `overflow`=0, `underflow`=0, `data_out`=0. Both pointers reset to 0. Memory contents are not reset.
- Reset mid-operation: `rst` overrides `wr_en`/`rd_en` in the same cycle, and every in-flight or pending word is discarded.

## Timing
- Write to flags: a write accepted at edge N makes `count`/`empty`/`full` reflect it immediately after edge N.
- Write to readable data: the word is readable from cycle N+1 (FWFT: valid on `data_out` after edge N).
- Standard read latency: 1 cycle. Data appears after the edge that accepts `rd_en`.
- FWFT read: zero-cycle presentation. The next word appears after the popping edge.
- Simultaneous read and write on an empty FIFO: the read is rejected and `underflow` is set; the write is accepted.
- Simultaneous read and write on a full FIFO: both are accepted and `count` stays DEPTH.
- Simultaneous read and write at any intermediate level: `count` is unchanged.
- Sustained throughput: one write and one read per cycle.

## Test plan
- Reset, then write 0x01..0x20 (DEPTH=32): `full`=1, `count`=32, `almost_full` first asserts after the 28th write. A 33rd write with `rd_en`=0 leaves `count`=32 and `overflow`=1.
- Drain the full FIFO, FWFT=0: `data_out` = 0x01..0x20 in order, each one cycle after its `rd_en`. `almost_empty` asserts at `count`=4 and `empty`=1 after the 32nd read. A further read sets `underflow`=1 and `data_out` stays 0x20.
- DEPTH=24, ADDR_WIDTH=5: 100 interleaved writes/reads keeping `count` between 10 and 24. Pointers wrap at 23→0, the output sequence matches the input with no loss, and neither error flag is set.
- Full with simultaneous `wr_en`=`rd_en`=1 (write 0xAA): `count` stays 32 and `overflow`=0. 0xAA is read out last.
- FWFT=1: a single write of 0x5C leaves `data_out`=0x5C and `empty`=0 the next cycle with no `rd_en`. A pop makes `empty`=1.
- With `count`=10, assert `rst` alongside `wr_en`: after the edge, `count`=0 and `empty`=1. With both `overflow` and `underflow` set, assert `clr_err` together with a new overflow event: `overflow` stays 1 and `underflow` clears.
